clk_div_ctrl: RTL



---
 rtl/clk_div_ctrl_pkg.sv | 19 +
 rtl/clk_div_phase_cnt.sv | 33 +++
 rtl/clk_div_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl shared types: FSM state encoding and divide-ratio clamp.
// Optional tick counter in clk_div_ctrl is enabled by CLK_DIV_CTRL_TICK_CNT_EN.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned clamp_div(
    input int unsigned d
  );
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter for clk_div_ctrl with zero-latency tick / square decode.
// Counts 0..div-1 while run is high; held at 0 when stopped or loaded.
module clk_div_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] div,
  output logic         tick,
  output logic         sq_en
);

  logic [W-1:0] phase;
  logic         last;

  assign last = (phase == div - W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= '0;
    end else if (load || !run || last) begin
      phase <= '0;
    end else begin
      phase <= phase + W'(1);
    end
  end

  assign tick  = run && last;
  assign sq_en = run && (phase < (div >> 1));

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider with boundary-aligned reconfiguration.
// Define CLK_DIV_CTRL_TICK_CNT_EN to add the 16-bit tick_cnt output.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int W           = 8,
  parameter int DIV_DEFAULT = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  input  logic         cfg_en,
  output logic         tick,
  output logic         sq_en,
  output logic         busy,
  output logic [W-1:0] cur_div
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  ,
  output logic [15:0]  tick_cnt
`endif
);

  state_t       state;
  logic [W-1:0] pend_div;
  logic         pend_en;
  logic         xfer;
  logic         run;
  logic         load;
  logic [W-1:0] req_div;

  assign xfer    = cfg_valid && cfg_ready;
  assign run     = (state != IDLE);
  assign req_div = W'(clamp_div(32'(cfg_div)));

  assign load = ((state == IDLE) && xfer && cfg_en)
             || ((state == PEND) && tick && pend_en);

  clk_div_phase_cnt #(
    .W(W)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .load (load),
    .div  (cur_div),
    .tick (tick),
    .sq_en(sq_en)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      cur_div   <= W'(DIV_DEFAULT);
      pend_div  <= '0;
      pend_en   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer && cfg_en) begin
            cur_div <= req_div;
            state   <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          // An accept on the terminal phase still waits a full period.
          if (xfer) begin
            pend_div  <= req_div;
            pend_en   <= cfg_en;
            state     <= PEND;
            cfg_ready <= 1'b0;
          end
        end
        PEND: begin
          if (tick) begin
            cfg_ready <= 1'b1;
            if (pend_en) begin
              cur_div <= pend_div;
              state   <= RUN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end
`endif

endmodule
